mips_debug_unit: RTL and testbench

- Host-side driver of the pipeline debug port: the master of `i_step`, `i_debug_mips_register_number` and `i_debug_address`, and the consumer of `o_mips_pc`, `o_mips_alu_result`, `o_mips_register_data` and `o_mips_data_memory`.
- Takes single-byte commands from a byte-stream receiver.
- Steps or runs the pipeline.
- Serializes a full state dump (PC, ALU result, 32 GPRs, data memory) into a byte stream for the transmitter.
- Sits between the UART wrapper and PIPELINE at top level.

---
 rtl/mips_debug_unit_pkg.sv | 33 +++
 rtl/mips_debug_unit_serializer.sv | 76 +++++++
 rtl/mips_debug_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_debug_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_debug_unit_pkg.sv
// Shared constants for the MIPS debug unit: host command codes, dump word
// indices and the controller state encoding.
// Optional build macro: DEBUG_DUMP_CHECKSUM_EN adds the checksum trailer states.
package mips_debug_unit_pkg;

  // Host command bytes (ASCII)
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_PAUSE = 8'h50;  // 'P'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

  // Word positions inside one state dump
  localparam int DUMP_IDX_PC   = 0;
  localparam int DUMP_IDX_ALU  = 1;
  localparam int DUMP_IDX_REG0 = 2;
  localparam int DUMP_IDX_MEM0 = 34;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STEP,
    ST_RUN,
    ST_SETUP,
    ST_CAPTURE,
    ST_SEND,
    ST_NEXT
`ifdef DEBUG_DUMP_CHECKSUM_EN
    ,
    ST_CKSUM,
    ST_CKSUM_SEND
`endif
  } state_t;

endpackage

// File: rtl/mips_debug_unit_serializer.sv
// Debug word serializer: loads an NB-bit word and hands it to the byte
// transmitter MSB first over a valid/ready handshake. After each accepted
// byte valid drops for one cycle, so the peak rate is one byte per 2 cycles.
// Optional build macro: DEBUG_DUMP_CHECKSUM_EN keeps a running XOR of all
// sent bytes and can load it as a single-byte trailer.
module mips_debug_unit_serializer #(
  parameter int NB      = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB-1:0]      i_word,
`ifdef DEBUG_DUMP_CHECKSUM_EN
  input  logic               i_clear,
  input  logic               i_load_cksum,
`endif
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_word_done
);

  localparam int NBYTES = NB / NB_BYTE;
  localparam int CW     = $clog2(NBYTES + 1);

  logic [NB-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          w_hs;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] r_xor;
`endif

  assign w_hs        = r_valid & i_tx_ready;
  assign o_tx_data   = r_shift[NB-1 -: NB_BYTE];
  assign o_tx_valid  = r_valid;
  assign o_word_done = w_hs & (r_cnt == CW'(1));

  // Shift register and byte handshake; data only moves on load or accept
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= CW'(NBYTES);
      r_valid <= 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    end else if (i_load_cksum) begin
      r_shift <= {r_xor, {(NB - NB_BYTE){1'b0}}};
      r_cnt   <= CW'(1);
      r_valid <= 1'b1;
`endif
    end else if (w_hs) begin
      r_shift <= r_shift << NB_BYTE;
      r_cnt   <= r_cnt - CW'(1);
      r_valid <= 1'b0;
    end else if (!r_valid && (r_cnt != '0)) begin
      r_valid <= 1'b1;
    end
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  // Running XOR of every accepted byte, cleared at the start of a dump
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_xor <= '0;
    end else if (w_hs) begin
      r_xor <= r_xor ^ o_tx_data;
    end
  end
`endif

endmodule

// File: rtl/mips_debug_unit.sv
// MIPS debug unit: decodes host command bytes, steps or runs the pipeline,
// and streams a full state dump (PC, ALU result, 32 GPRs, data memory)
// to the byte transmitter. The pipeline is never stepped during a dump.
// Optional build macro: DEBUG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module mips_debug_unit
  import mips_debug_unit_pkg::*;
#(
  parameter int NB              = 32,
  parameter int NB_REG_SEL      = 5,
  parameter int TAM_DATA_MEMORY = 16,
  parameter int NB_BYTE         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_step,
  output logic [NB_REG_SEL-1:0] o_debug_reg_num,
  output logic [NB-1:0]         o_debug_address,
  input  logic [NB-1:0]         i_mips_pc,
  input  logic [NB-1:0]         i_mips_alu_result,
  input  logic [NB-1:0]         i_mips_register_data,
  input  logic [NB-1:0]         i_mips_data_memory,
  output logic                  o_busy
);

  localparam int NUM_WORDS = DUMP_IDX_MEM0 + TAM_DATA_MEMORY;
  localparam int KW        = $clog2(NUM_WORDS);
  localparam logic [KW-1:0] K_PC   = KW'(DUMP_IDX_PC);
  localparam logic [KW-1:0] K_ALU  = KW'(DUMP_IDX_ALU);
  localparam logic [KW-1:0] K_REG0 = KW'(DUMP_IDX_REG0);
  localparam logic [KW-1:0] K_MEM0 = KW'(DUMP_IDX_MEM0);
  localparam logic [KW-1:0] K_LAST = KW'(NUM_WORDS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [KW-1:0]         r_k;
  logic [NB_REG_SEL-1:0] r_reg_num;
  logic [NB-1:0]         r_addr;
  logic [NB-1:0]         w_capture_word;
  logic                  w_load;
  logic                  w_word_done;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic                  w_clear;
  logic                  w_load_cksum;
`endif

  assign o_step          = (r_state == ST_STEP) || (r_state == ST_RUN);
  assign o_busy          = (r_state != ST_IDLE) && (r_state != ST_RUN);
  assign o_debug_reg_num = r_reg_num;
  assign o_debug_address = r_addr;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and serializer strobes
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    w_clear      = 1'b0;
    w_load_cksum = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_STEP: w_next = ST_STEP;
            CMD_RUN:  w_next = ST_RUN;
            CMD_DUMP: w_next = ST_SETUP;
            default:  w_next = ST_IDLE;
          endcase
        end
      end
      ST_STEP: w_next = ST_SETUP;
      ST_RUN: begin
        if (i_rx_valid && (i_rx_data == CMD_PAUSE)) w_next = ST_SETUP;
      end
      ST_SETUP: w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_load = 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        w_clear = (r_k == K_PC);
`endif
        w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_word_done) w_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_k == K_LAST) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
          w_next = ST_CKSUM;
`else
          w_next = ST_IDLE;
`endif
        end else begin
          w_next = ST_SETUP;
        end
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      ST_CKSUM: begin
        w_load_cksum = 1'b1;
        w_next       = ST_CKSUM_SEND;
      end
      ST_CKSUM_SEND: begin
        if (w_word_done) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Dump word index; returns to zero after the last word so every dump starts at PC
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_k <= '0;
    end else if (r_state == ST_NEXT) begin
      r_k <= (r_k == K_LAST) ? '0 : r_k + KW'(1);
    end
  end

  // Debug selects update in SETUP and stay put through CAPTURE so the
  // combinational pipeline read has a full cycle to settle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_reg_num <= '0;
      r_addr    <= '0;
    end else if (r_state == ST_SETUP) begin
      if ((r_k >= K_REG0) && (r_k < K_MEM0)) begin
        r_reg_num <= NB_REG_SEL'(r_k - K_REG0);
      end else if (r_k >= K_MEM0) begin
        r_addr <= NB'(r_k - K_MEM0) << 2;
      end
    end
  end

  // Source select for the word being captured
  always_comb begin
    w_capture_word = i_mips_data_memory;
    if (r_k == K_PC) begin
      w_capture_word = i_mips_pc;
    end else if (r_k == K_ALU) begin
      w_capture_word = i_mips_alu_result;
    end else if (r_k < K_MEM0) begin
      w_capture_word = i_mips_register_data;
    end
  end

  mips_debug_unit_serializer #(
    .NB      (NB),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_word       (w_capture_word),
`ifdef DEBUG_DUMP_CHECKSUM_EN
    .i_clear      (w_clear),
    .i_load_cksum (w_load_cksum),
`endif
    .i_tx_ready   (i_tx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .o_word_done  (w_word_done)
  );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Directed bench for mips_debug_unit with a small pipeline stub
// (PC advancing by 4 per step, fixed GPR and memory contents).
module tb_mips_debug_unit;

`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int DUMP_BYTES = 201;
`else
  localparam int DUMP_BYTES = 200;
`endif
  localparam int CAP_MAX = 2048;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_step;
  logic [4:0]  o_debug_reg_num;
  logic [31:0] o_debug_address;
  logic [31:0] i_mips_pc;
  logic [31:0] i_mips_alu_result;
  logic [31:0] i_mips_register_data;
  logic [31:0] i_mips_data_memory;
  logic        o_busy;

  // pipeline stub
  logic [31:0] pc = '0;
  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:15];

  // byte collector
  logic [7:0]  cap      [0:CAP_MAX-1];
  logic [31:0] cap_addr [0:CAP_MAX-1];
  logic [4:0]  cap_reg  [0:CAP_MAX-1];
  int          n_bytes  = 0;
  int          step_cnt = 0;
  int          stab_err = 0;
  logic        hold_prev = 1'b0;
  logic [7:0]  held = '0;

  int tests = 0;
  int fails = 0;
  int mode  = 0;

  always #5 clk = ~clk;

  mips_debug_unit dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_rx_data            (i_rx_data),
    .i_rx_valid           (i_rx_valid),
    .o_tx_data            (o_tx_data),
    .o_tx_valid           (o_tx_valid),
    .i_tx_ready           (i_tx_ready),
    .o_step               (o_step),
    .o_debug_reg_num      (o_debug_reg_num),
    .o_debug_address      (o_debug_address),
    .i_mips_pc            (i_mips_pc),
    .i_mips_alu_result    (i_mips_alu_result),
    .i_mips_register_data (i_mips_register_data),
    .i_mips_data_memory   (i_mips_data_memory),
    .o_busy               (o_busy)
  );

  assign i_mips_pc            = pc;
  assign i_mips_alu_result    = pc ^ 32'hA5A5_0000;
  assign i_mips_register_data = regs[o_debug_reg_num];
  assign i_mips_data_memory   = mem[o_debug_address[5:2]];

  always @(posedge clk) begin
    if (!i_reset && o_step) pc <= pc + 32'd4;
  end

  always @(negedge clk) begin
    if (hold_prev && !i_reset && (!o_tx_valid || (o_tx_data !== held))) stab_err++;
    hold_prev = o_tx_valid && !i_tx_ready;
    held      = o_tx_data;
    if (o_tx_valid && i_tx_ready && (n_bytes < CAP_MAX)) begin
      cap[n_bytes]      = o_tx_data;
      cap_addr[n_bytes] = o_debug_address;
      cap_reg[n_bytes]  = o_debug_reg_num;
      n_bytes++;
    end
    if (!i_reset && o_step) step_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (mode == 1) i_tx_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    cyc();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (o_busy && (c < budget)) begin
      cyc();
      c++;
    end
    check({tag, "_timeout"}, (c < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input int b, input logic [31:0] pcv);
    int w  = b / 4;
    int sh = 3 - (b % 4);
    logic [31:0] word;
    if (w == 0)       word = pcv;
    else if (w == 1)  word = pcv ^ 32'hA5A5_0000;
    else if (w < 34)  word = regs[w - 2];
    else              word = mem[w - 34];
    return word[sh*8 +: 8];
  endfunction

  task automatic check_dump(input string tag, input int start, input logic [31:0] pcv);
    int mism = 0;
    logic [7:0] x = '0;
    for (int i = 0; i < 200; i++) begin
      if (cap[start + i] !== exp_byte(i, pcv)) mism++;
      x = x ^ cap[start + i];
    end
    check({tag, "_bytes"}, mism, 0);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    check({tag, "_cksum"}, {24'h0, cap[start + 200]}, {24'h0, x});
`endif
  endtask

  initial begin
    int b;
    int b_step;
    int s0;
    int mism;
    int c;

    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    regs[2] = 32'hDEAD_BEEF;
    for (int j = 0; j < 16; j++) mem[j] = 32'hC000_0000 | j;
    mem[3] = 32'h0000_002A;

    i_reset    = 1'b1;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b1;
    repeat (3) cyc();
    i_reset = 1'b0;

    check("rst_tx_valid", {31'h0, o_tx_valid}, 32'd0);
    check("rst_tx_data",  {24'h0, o_tx_data}, 32'd0);
    check("rst_step",     {31'h0, o_step}, 32'd0);
    check("rst_reg_num",  {27'h0, o_debug_reg_num}, 32'd0);
    check("rst_address",  o_debug_address, 32'd0);
    check("rst_busy",     {31'h0, o_busy}, 32'd0);

    // single step then dump, ready always high
    s0 = step_cnt;
    b  = n_bytes;
    send_cmd(8'h53);
    wait_idle("step", 3000);
    check("step_pulses", step_cnt - s0, 1);
    check("step_count", n_bytes - b, DUMP_BYTES);
    check("step_pc_bytes", {cap[b], cap[b+1], cap[b+2], cap[b+3]}, 32'h0000_0004);
    check_dump("step", b, 32'd4);
    b_step = b;

    // dump with ready asserted about one cycle in three
    mode = 1;
    s0 = step_cnt;
    b  = n_bytes;
    send_cmd(8'h44);
    wait_idle("dump", 10000);
    mode = 0;
    i_tx_ready = 1'b1;
    check("dump_count", n_bytes - b, DUMP_BYTES);
    check("dump_no_step", step_cnt - s0, 0);
    check("dump_gpr2", {cap[b+16], cap[b+17], cap[b+18], cap[b+19]}, 32'hDEAD_BEEF);
    check("dump_mem3", {cap[b+148], cap[b+149], cap[b+150], cap[b+151]}, 32'h0000_002A);
    check("dump_mem3_addr", cap_addr[b+148], 32'd12);
    check("dump_gpr2_sel", {27'h0, cap_reg[b+16]}, 32'd2);
    check_dump("dump", b, 32'd4);
    mism = 0;
    for (int i = 0; i < DUMP_BYTES; i++) if (cap[b + i] !== cap[b_step + i]) mism++;
    check("dump_same_as_ready_high", mism, 0);
    check("dump_stable_hold", stab_err, 0);

    // run for 10 cycles, pause, then a dropped 'S' mid-dump
    s0 = step_cnt;
    b  = n_bytes;
    send_cmd(8'h52);
    check("run_step_high", {31'h0, o_step}, 32'd1);
    check("run_not_busy", {31'h0, o_busy}, 32'd0);
    repeat (9) cyc();
    send_cmd(8'h50);
    check("pause_step_low", {31'h0, o_step}, 32'd0);
    repeat (20) cyc();
    send_cmd(8'h53);
    wait_idle("run", 3000);
    check("run_pulses", step_cnt - s0, 10);
    check("run_count", n_bytes - b, DUMP_BYTES);
    check("run_pc_bytes", {cap[b], cap[b+1], cap[b+2], cap[b+3]}, 32'h0000_002C);
    check_dump("run", b, 32'd44);
    repeat (20) cyc();
    check("mid_dump_s_ignored_busy", {31'h0, o_busy}, 32'd0);
    check("mid_dump_s_ignored_step", step_cnt - s0, 10);
    check("mid_dump_s_ignored_bytes", n_bytes - b, DUMP_BYTES);

    // reset while bytes are going out
    b = n_bytes;
    send_cmd(8'h44);
    c = 0;
    while (!(o_tx_valid && ((n_bytes - b) >= 10)) && (c < 2000)) begin
      cyc();
      c++;
    end
    check("rst_mid_reach_send", (c < 2000) ? 32'd1 : 32'd0, 32'd1);
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    check("rst_mid_tx_valid", {31'h0, o_tx_valid}, 32'd0);
    check("rst_mid_busy", {31'h0, o_busy}, 32'd0);
    check("rst_mid_tx_data", {24'h0, o_tx_data}, 32'd0);
    repeat (5) cyc();
    b = n_bytes;
    send_cmd(8'h44);
    wait_idle("after_rst", 3000);
    check("after_rst_count", n_bytes - b, DUMP_BYTES);
    check_dump("after_rst", b, 32'd44);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
